mem_req_ctrl: RTL and testbench

Request controller directly upstream of the 32-bit single-port simulation RAM. It accepts read/write requests from a processing pipeline over a valid/ready interface, drives the RAM's single-cycle read/write strobes, and rejects out-of-range addresses. It absorbs the RAM's one-cycle read latency and returns read data in order through a small response FIFO with backpressure. It also sequences the RAM's synchronous, active-high initialisation reset after system reset.

---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/mem_req_ctrl_rsp_fifo.sv | 52 +++++
 rtl/mem_req_ctrl.sv | 131 +++++++++++++
 tb/tb_mem_req_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and widths for the memory request controller and its response FIFO.
package mem_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int ERRCNT_W = 16;

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_entry_t;

endpackage

// File: rtl/mem_req_ctrl_rsp_fifo.sv
// Synchronous response FIFO; the head entry reads as zero while empty.
module rsp_fifo
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  rsp_entry_t             wr_entry,
  output rsp_entry_t             rd_entry,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  rsp_entry_t       mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_entry = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request controller in front of the single-port RAM: range check, strobe generation,
// read-latency pipe into an in-order response FIFO, and RAM init sequencing.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int INIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [DATA_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                mem_reset,
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                init_done,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam int CNT_W    = $clog2(RSP_DEPTH) + 1;
  localparam int INIT_W   = $clog2(INIT_CYCLES + 1);
  localparam int ADDR_LIM = 2**ADDR_W;

  state_t                   state_q, state_d;
  logic [INIT_W-1:0]        init_cnt;
  logic signed [DATA_W-1:0] addr_s;
  logic                     in_range;
  logic                     accept;
  logic                     p_valid;
  logic                     p_err;
  logic [CNT_W-1:0]         fifo_count;
  logic [CNT_W:0]           occupancy;
  logic                     fifo_full;
  logic                     fifo_empty;
  rsp_entry_t               push_entry;
  rsp_entry_t               head_entry;
  logic [1:0]               err_inc;
  logic [ERRCNT_W:0]        err_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= INIT;
      init_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_cnt == INIT_W'(INIT_CYCLES - 1)) state_d = RUN;
  end

  assign addr_s    = req_addr;
  assign in_range  = (addr_s >= 0) && (addr_s < ADDR_LIM);
  // Reads still in the pipe count against FIFO space, so an accepted read always has a slot.
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(p_valid);

  always_comb begin
    mem_reset = (state_q == INIT);
    init_done = (state_q == RUN);
    req_ready = (state_q == RUN) && !fifo_full && (occupancy < (CNT_W+1)'(RSP_DEPTH));
    accept    = req_valid && req_ready;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (accept && in_range) begin
      mem_addr = req_addr;
      if (req_write) begin
        mem_write = 1'b1;
        mem_wdata = req_wdata;
      end else begin
        mem_read = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_valid <= 1'b0;
      p_err   <= 1'b0;
    end else begin
      p_valid <= accept && !req_write;
      if (accept && !req_write) p_err <= !in_range;
    end
  end

  assign push_entry.data = p_err ? '0 : mem_rdata;
  assign push_entry.err  = p_err;

  rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (p_valid),
    .pop      (rsp_valid && rsp_ready),
    .wr_entry (push_entry),
    .rd_entry (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = head_entry.data;
  assign rsp_err   = head_entry.err;

  // A rejected write and a rejected read leaving the pipe can land in the same cycle.
  assign err_inc = 2'(accept && req_write && !in_range) + 2'(p_valid && p_err);
  assign err_sum = {1'b0, err_count} + (ERRCNT_W+1)'(err_inc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_count <= '0;
    else        err_count <= err_sum[ERRCNT_W] ? '1 : err_sum[ERRCNT_W-1:0];
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Randomized and directed bench for mem_req_ctrl against a queue-based response model.
module tb_mem_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic        mem_reset, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        init_done;
  logic [15:0] err_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mem_req_ctrl #(.ADDR_W(4), .RSP_DEPTH(4), .INIT_CYCLES(2)) dut (
    .clk(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_reset(mem_reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .init_done(init_done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Simple RAM environment: sync clear while mem_reset, registered read.
  logic [31:0] ram [16];
  always @(posedge clk) begin
    if (mem_reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_write) ram[mem_addr[3:0]] <= mem_wdata;
      if (mem_read)  mem_rdata <= ram[mem_addr[3:0]];
    end
  end

  // Reference model: every accepted read becomes an expected response, visible two cycles later.
  typedef struct {
    logic [31:0] d;
    logic        e;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [31:0] shadow [16];
  int          cyc;
  int          exp_err;
  int          err_pend;
  bit          run_m;
  int          init_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_err   = 0;
    err_pend  = 0;
    run_m     = 0;
    init_left = 2;
    for (int i = 0; i < 16; i++) shadow[i] = '0;
  endtask

  // Called at posedge+1: drives inputs, checks at negedge, advances the model over the next edge.
  task automatic step(input logic v, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic rr);
    bit exp_ready, acc, inr, exp_rv;
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; rsp_ready = rr;
    @(negedge clk);
    exp_ready = run_m && (q.size() < 4);
    acc       = v && exp_ready;
    inr       = ($signed(a) >= 0) && ($signed(a) < 16);
    exp_rv    = (q.size() > 0) && (q[0].t + 2 <= cyc);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("mem_reset", 32'(mem_reset), 32'(!run_m));
    check("init_done", 32'(init_done), 32'(run_m));
    check("mem_write", 32'(mem_write), 32'(acc && w && inr));
    check("mem_read",  32'(mem_read),  32'(acc && !w && inr));
    check("mem_addr",  mem_addr,  (acc && inr) ? a : 32'd0);
    check("mem_wdata", mem_wdata, (acc && w && inr) ? d : 32'd0);
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      check("rsp_data", rsp_data, q[0].d);
      check("rsp_err",  32'(rsp_err), 32'(q[0].e));
    end
    check("err_count", 32'(err_count), 32'(exp_err));
    if (exp_rv && rr) void'(q.pop_front());
    exp_err += err_pend;
    err_pend = 0;
    if (acc) begin
      if (w) begin
        if (inr) shadow[a[3:0]] = d;
        else     exp_err++;
      end else begin
        q.push_back('{d: inr ? shadow[a[3:0]] : 32'd0, e: !inr, t: cyc});
        if (!inr) err_pend = 1;
      end
    end
    if (rst_n && !run_m) begin
      init_left--;
      if (init_left == 0) run_m = 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, rr);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r = $urandom_range(0, 9);
    if (r < 8)       return 32'($urandom_range(0, 15));
    else if (r == 8) return 32'($urandom_range(16, 1000));
    else             return 32'(0 - int'($urandom_range(1, 1000)));
  endfunction

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), rand_addr(), $urandom,
           $urandom_range(0, 3) != 0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    cyc = 0;
    model_clear();
    @(posedge clk); #1;

    // Reset held for 3 cycles, then INIT sequence.
    idle(3, 1'b0);
    rst_n = 1'b1;
    idle(4, 1'b1);

    // Write then read back with RAW.
    step(1'b1, 1'b1, 32'd5, 32'hFFFF_FFF9, 1'b1);
    step(1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
    idle(4, 1'b1);

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'(i), 32'd0, 1'b1);
    idle(4, 1'b1);

    step(1'b1, 1'b0, 32'd16, 32'd0, 1'b1);
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd123, 1'b1);
    step(1'b1, 1'b0, 32'd3, 32'd0, 1'b1);
    idle(4, 1'b1);
    check("err_count_after_oob", 32'(err_count), 32'd2);

    // Backpressure: exactly four reads fit, then drain.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'(i), 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'(i + 8), 32'd0, 1'b1);
    idle(4, 1'b1);

    random_run(2000);
    idle(6, 1'b1);

    // Reset with responses queued.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(i), 32'd0, 1'b0);
    idle(3, 1'b0);
    check("queued_before_reset", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("rsp_valid_async_reset", 32'(rsp_valid), 32'd0);
    check("mem_reset_async_reset", 32'(mem_reset), 32'd1);
    idle(2, 1'b1);
    rst_n = 1'b1;
    idle(8, 1'b1);

    random_run(500);
    idle(8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
